// File: rtl/mips_alu_pkg.sv
// Shared ALU control codes and multi-cycle sequencer state encoding.
package mips_alu_pkg;

  // Single-cycle ALU control codes
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  // Multi-cycle codes handled by mult_div_sequencer
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIV   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

  // Codes 1000..1011 belong to the multiply/divide unit
  function automatic logic is_mdu_op(input logic [3:0] code);
    return (code[3:2] == 2'b10);
  endfunction

  // Even codes of the group are the signed variants
  function automatic logic is_signed_op(input logic [3:0] code);
    return ~code[0];
  endfunction

  function automatic logic is_div_op(input logic [3:0] code);
    return code[1];
  endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// One iteration of shift-add multiply or restoring divide on a 2*WIDTH work register.
//   i_is_div   : 1 = restoring divide step, 0 = shift-add multiply step
//   i_work     : current work register {upper, lower}
//   i_operand  : multiplicand (mult) or divisor (div)
//   o_work_nxt : work register after one step
module mdu_shift_core
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 i_is_div,
  input  logic [2*WIDTH-1:0]   i_work,
  input  logic [WIDTH-1:0]     i_operand,
  output logic [2*WIDTH-1:0]   o_work_nxt
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum      = {1'b0, i_work[2*WIDTH-1:WIDTH]} + {1'b0, i_operand};
    // Remainder shifted left with the next dividend bit pulled in
    w_rem_sh   = i_work[2*WIDTH-1:WIDTH-1];
    w_diff     = w_rem_sh - {1'b0, i_operand};
    o_work_nxt = i_work;
    if (i_is_div) begin
      // Top bit of the difference is the borrow: set means restore
      if (!w_diff[WIDTH]) begin
        o_work_nxt = {w_diff[WIDTH-1:0], i_work[WIDTH-2:0], 1'b1};
      end else begin
        o_work_nxt = {w_rem_sh[WIDTH-1:0], i_work[WIDTH-2:0], 1'b0};
      end
    end else if (i_work[0]) begin
      // Carry out of the add becomes the new MSB after the right shift
      o_work_nxt = {w_sum, i_work[WIDTH-1:1]};
    end else begin
      o_work_nxt = {1'b0, i_work[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle mult/multu/div/divu sequencer owning the HI/LO registers.
//   clk, rst_n        : clock, async active-low reset
//   start, alu_ctrl   : issue request and ALU code (sampled in IDLE)
//   op_a, op_b        : multiplicand/dividend, multiplier/divisor
//   flush             : cancel in-flight op, HI/LO untouched
//   hi_we, lo_we,
//   wr_data           : mthi/mtlo writes, honoured in IDLE only
//   busy, done        : registered status; done is a one-cycle pulse
//   hi, lo            : HI/LO architectural registers
module mult_div_sequencer
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  mdu_state_t           r_state,   w_state_nxt;
  logic [CNT_W-1:0]     r_count,   w_count_nxt;
  logic [2*WIDTH-1:0]   r_work,    w_work_nxt;
  logic [WIDTH-1:0]     r_operand, w_operand_nxt;
  logic                 r_is_div,  w_is_div_nxt;
  logic                 r_neg_q,   w_neg_q_nxt;
  logic                 r_neg_r,   w_neg_r_nxt;
  logic                 r_div0,    w_div0_nxt;
  logic [WIDTH-1:0]     r_hi,      w_hi_nxt;
  logic [WIDTH-1:0]     r_lo,      w_lo_nxt;
  logic                 r_busy;
  logic                 r_done,    w_done_nxt;

  logic [2*WIDTH-1:0]   w_core_nxt;
  logic                 w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo, w_rem;

  mdu_shift_core #(.WIDTH(WIDTH)) u_core (
    .i_is_div   (r_is_div),
    .i_work     (r_work),
    .i_operand  (r_operand),
    .o_work_nxt (w_core_nxt)
  );

  // Operand magnitudes and final sign correction
  always_comb begin
    w_a_neg = is_signed_op(alu_ctrl) & op_a[WIDTH-1];
    w_b_neg = is_signed_op(alu_ctrl) & op_b[WIDTH-1];
    w_abs_a = w_a_neg ? -op_a : op_a;
    w_abs_b = w_b_neg ? -op_b : op_b;
    w_prod  = r_neg_q ? -r_work : r_work;
    w_quo   = r_neg_q ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0];
    if (r_div0) begin
      w_quo = '1;
    end
    // Remainder of a zero divide is the raw dividend, restored by this negate
    w_rem   = r_neg_r ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_work_nxt    = r_work;
    w_operand_nxt = r_operand;
    w_is_div_nxt  = r_is_div;
    w_neg_q_nxt   = r_neg_q;
    w_neg_r_nxt   = r_neg_r;
    w_div0_nxt    = r_div0;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (hi_we) w_hi_nxt = wr_data;
        if (lo_we) w_lo_nxt = wr_data;
        if (start && !flush && is_mdu_op(alu_ctrl)) begin
          w_state_nxt  = ST_RUN;
          w_count_nxt  = CNT_W'(WIDTH);
          w_is_div_nxt = is_div_op(alu_ctrl);
          w_neg_q_nxt  = w_a_neg ^ w_b_neg;
          w_neg_r_nxt  = w_a_neg;
          w_div0_nxt   = (op_b == '0);
          if (is_div_op(alu_ctrl)) begin
            w_work_nxt    = {{WIDTH{1'b0}}, w_abs_a};
            w_operand_nxt = w_abs_b;
          end else begin
            w_work_nxt    = {{WIDTH{1'b0}}, w_abs_b};
            w_operand_nxt = w_abs_a;
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_work_nxt  = w_core_nxt;
          w_count_nxt = r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) w_state_nxt = ST_FIX;
        end
      end
      ST_FIX: begin
        w_state_nxt = ST_IDLE;
        if (!flush) begin
          w_done_nxt = 1'b1;
          if (r_is_div) begin
            w_hi_nxt = w_rem;
            w_lo_nxt = w_quo;
          end else begin
            w_hi_nxt = w_prod[2*WIDTH-1:WIDTH];
            w_lo_nxt = w_prod[WIDTH-1:0];
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_work    <= '0;
      r_operand <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_work    <= w_work_nxt;
      r_operand <= w_operand_nxt;
      r_is_div  <= w_is_div_nxt;
      r_neg_q   <= w_neg_q_nxt;
      r_neg_r   <= w_neg_r_nxt;
      r_div0    <= w_div0_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed corner cases plus random ops.
module tb_mult_div_sequencer;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int total;
  int bad;

  mult_div_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (c)
      4'b1000: return 64'(sa * sb);
      4'b1001: return ua * ub;
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (c == 4'b1010) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {32'(a % b), 32'(a / b)};
      end
    endcase
  endfunction

  // Issue one op, wait for done, check latency and HI/LO against the model
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] e;
    int n;
    e = model(c, a, b);
    start = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(WIDTH + 1));
    chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int dones;
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; alu_ctrl = 4'h0; op_a = '0; op_b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed arithmetic corners
    run_op("multu_max", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_hi_c", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max_lo_c", 64'(lo), 64'h0000_0001);
    tick();
    chk("done_pulse", 64'(done), 64'd0);
    run_op("mult_neg", 4'b1000, 32'hFFFF_FFFD, 32'd5);
    chk("mult_neg_lo_c", 64'(lo), 64'hFFFF_FFF1);
    run_op("div_neg", 4'b1010, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_lo_c", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg_hi_c", 64'(hi), 64'hFFFF_FFFF);
    run_op("divu_zero", 4'b1011, 32'd100, 32'd0);
    chk("divu_zero_lo_c", 64'(lo), 64'hFFFF_FFFF);
    run_op("div_zero_neg", 4'b1010, 32'hFFFF_FF00, 32'd0);
    run_op("div_ovf", 4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_c", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi_c", 64'(hi), 64'h0);

    // Back-to-back: new start accepted in the done cycle
    start = 1'b1; alu_ctrl = 4'b1001; op_a = 32'd7; op_b = 32'd6;
    tick();
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    repeat (WIDTH + 1) tick();
    chk("b2b_done", 64'(done), 64'd1);
    chk("b2b_lo", 64'(lo), 64'd42);

    // Non-MDU code ignores start
    start = 1'b1; alu_ctrl = 4'b0010;
    tick();
    start = 1'b0;
    chk("nonmdu_busy", 64'(busy), 64'd0);

    // Flush mid-run keeps prior HI/LO and produces no done
    run_op("pre_flush", 4'b1011, 32'd5, 32'd2);
    start = 1'b1; alu_ctrl = 4'b1001; op_a = 32'h1234; op_b = 32'h5678;
    tick();
    start = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dones++;
    end
    chk("flush_dones", 64'(dones), 64'd0);
    chk("flush_hi", 64'(hi), 64'd1);
    chk("flush_lo", 64'(lo), 64'd2);

    // Flush beats a same-cycle start in IDLE
    start = 1'b1; flush = 1'b1; alu_ctrl = 4'b1000;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 64'(busy), 64'd0);

    // Start while busy is ignored: exactly one done, first op's result
    start = 1'b1; alu_ctrl = 4'b1001; op_a = 32'd11; op_b = 32'd13;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1; alu_ctrl = 4'b1001; op_a = 32'd3; op_b = 32'd3;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) dones++;
    end
    chk("busy_start_dones", 64'(dones), 64'd1);
    chk("busy_start_lo", 64'(lo), 64'd143);

    // mthi/mtlo in IDLE, both in one cycle
    hi_we = 1'b1; wr_data = 32'hA5A5_A5A5;
    tick();
    hi_we = 1'b0;
    chk("mthi", 64'(hi), 64'hA5A5_A5A5);
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h0BAD_F00D;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo_hi", 64'(hi), 64'h0BAD_F00D);
    chk("mthilo_lo", 64'(lo), 64'h0BAD_F00D);

    // mtlo while busy is dropped
    start = 1'b1; alu_ctrl = 4'b1011; op_a = 32'd50; op_b = 32'd7;
    tick();
    start = 1'b0;
    lo_we = 1'b1; wr_data = 32'h1111_1111;
    tick();
    lo_we = 1'b0;
    chk("mtlo_busy", 64'(lo), 64'h0BAD_F00D);
    repeat (WIDTH) tick();
    chk("mtlo_busy_res", 64'(lo), 64'd7);

    // mthi with an accepted start: write lands and op still runs
    start = 1'b1; hi_we = 1'b1; wr_data = 32'hCAFE_0001;
    alu_ctrl = 4'b1011; op_a = 32'd50; op_b = 32'd8;
    tick();
    start = 1'b0; hi_we = 1'b0;
    chk("mthi_start_hi", 64'(hi), 64'hCAFE_0001);
    chk("mthi_start_busy", 64'(busy), 64'd1);
    repeat (WIDTH + 1) tick();
    chk("mthi_start_res", 64'(hi), 64'd2);

    // Async reset mid-run
    start = 1'b1; alu_ctrl = 4'b1000; op_a = 32'd99; op_b = 32'd99;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("post_rst", 4'b1011, 32'd9, 32'd4);

    // Random ops against the model
    for (int i = 0; i < 24; i++) begin
      rc = 4'b1000 | 4'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 255));
        2: rb = -32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op("rand", rc, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
